// File: rtl/issue_queue_pkg.sv
// ---------------------------------------------------------------------------
// issue_queue_pkg
//   Shared types and sizing constants for the decode -> issue boundary.
//   Decode, the issue queue and the issue stage all import this package so
//   they agree on the entry layout and on the queue depth.
//
//   Contents:
//     REG_WIDTH / REG_ADDR   architectural register width and index type
//     bool, TRUE, FALSE      single-bit flag type and its values
//     IQ_DEPTH               issue queue depth used by producer and consumer
//     ISSUE_QUEUE_ELEMENT    one decoded instruction waiting to issue
//     iq_clamp_pop()         limits a pop request to the entries on offer
// ---------------------------------------------------------------------------
package issue_queue_pkg;

  localparam int unsigned REG_WIDTH = 32;
  localparam int unsigned IQ_DEPTH  = 8;

  typedef logic [4:0] REG_ADDR;
  typedef logic       bool;

  localparam bool TRUE  = 1'b1;
  localparam bool FALSE = 1'b0;

  typedef struct packed {
    logic [REG_WIDTH-1:0] pc;
    REG_ADDR              rs1;
    REG_ADDR              rs2;
    REG_ADDR              rd;
    bool                  rd_valid;
    logic [REG_WIDTH-1:0] imm;
  } ISSUE_QUEUE_ELEMENT;

  // Issue may only take entries that are actually presented; anything beyond
  // that is clamped so the occupancy count can never underflow.
  function automatic logic [1:0] iq_clamp_pop(input logic [1:0] req,
                                              input logic [1:0] avail);
    return (req > avail) ? avail : req;
  endfunction

endpackage

// File: rtl/issue_queue_mem.sv
// ---------------------------------------------------------------------------
// issue_queue_mem
//   DEPTH-entry storage for the issue queue. Two synchronous write ports and
//   two asynchronous read ports; no reset so it can map onto distributed RAM.
//
//   Ports:
//     clk                    write clock
//     i_we0/i_waddr0/i_wdata0  write port 0
//     i_we1/i_waddr1/i_wdata1  write port 1 (never the same address as port 0
//                            when both are enabled)
//     i_raddr0/o_rdata0      combinational read port 0
//     i_raddr1/o_rdata1      combinational read port 1
// ---------------------------------------------------------------------------
module issue_queue_mem
  import issue_queue_pkg::*;
#(
  parameter int unsigned DEPTH = IQ_DEPTH,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               i_we0,
  input  logic [AW-1:0]      i_waddr0,
  input  ISSUE_QUEUE_ELEMENT i_wdata0,
  input  logic               i_we1,
  input  logic [AW-1:0]      i_waddr1,
  input  ISSUE_QUEUE_ELEMENT i_wdata1,
  input  logic [AW-1:0]      i_raddr0,
  output ISSUE_QUEUE_ELEMENT o_rdata0,
  input  logic [AW-1:0]      i_raddr1,
  output ISSUE_QUEUE_ELEMENT o_rdata1
);

  ISSUE_QUEUE_ELEMENT r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we0) begin
      r_mem[i_waddr0] <= i_wdata0;
    end
    if (i_we1) begin
      r_mem[i_waddr1] <= i_wdata1;
    end
  end

  assign o_rdata0 = r_mem[i_raddr0];
  assign o_rdata1 = r_mem[i_raddr1];

endmodule

// File: rtl/issue_queue.sv
// ---------------------------------------------------------------------------
// issue_queue
//   Circular FIFO between decode and issue. Decode pushes up to two entries
//   per cycle; the two oldest entries are presented to issue, which pops 0..2
//   per cycle. Pointer and occupancy logic live here, storage lives in
//   issue_queue_mem.
//
//   Ports:
//     clk            rising-edge clock
//     rst            synchronous active-high reset
//     flash          pipeline flush, empties the queue (beats push/pop)
//     push_number    valid entries on push_data (0..2; 3 treated as 0)
//     push_data      entries from decode, index 0 is the older
//     push_ready     at least two free slots (registered count only)
//     issue_require  oldest [0] and second-oldest [1] entries, zero if absent
//     iq_size        min(count, 2)
//     iq_pop_number  entries consumed by issue this cycle
//     iq_count       registered occupancy
//     stall_cycles   (ISSUE_QUEUE_STATS_EN only) saturating count of cycles
//                    where decode offered entries but push_ready was low;
//                    cleared by rst, not by flash
//
//   Optional build macro: ISSUE_QUEUE_STATS_EN
// ---------------------------------------------------------------------------
module issue_queue
  import issue_queue_pkg::*;
#(
  parameter int unsigned DEPTH = IQ_DEPTH,
  parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flash,
  input  logic [1:0]               push_number,
  input  ISSUE_QUEUE_ELEMENT [1:0] push_data,
  output logic                     push_ready,
  output ISSUE_QUEUE_ELEMENT [1:0] issue_require,
  output logic [1:0]               iq_size,
  input  logic [1:0]               iq_pop_number,
  output logic [CNT_W-1:0]         iq_count
`ifdef ISSUE_QUEUE_STATS_EN
  ,
  output logic [31:0]              stall_cycles
`endif
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW-1:0]      r_head;
  logic [AW-1:0]      r_tail;
  logic [CNT_W-1:0]   r_count;

  logic [CNT_W-1:0]   w_free;
  logic               w_push_ready;
  logic [1:0]         w_push_legal;
  logic [1:0]         w_accept;
  logic [1:0]         w_iq_size;
  logic [1:0]         w_eff_pop;
  logic               w_update;
  ISSUE_QUEUE_ELEMENT w_rdata0;
  ISSUE_QUEUE_ELEMENT w_rdata1;

  // Readiness looks only at the registered count; a pop in the same cycle is
  // deliberately not credited so the ready path stays short.
  assign w_free       = CNT_W'(DEPTH) - r_count;
  assign w_push_ready = (w_free >= CNT_W'(2));

  assign w_push_legal = (push_number == 2'd3) ? 2'd0 : push_number;
  assign w_accept     = w_push_ready ? w_push_legal : 2'd0;

  assign w_iq_size    = (r_count >= CNT_W'(2)) ? 2'd2 : r_count[1:0];
  assign w_eff_pop    = iq_clamp_pop(iq_pop_number, w_iq_size);

  // Reset and flush both discard any same-cycle push.
  assign w_update     = !rst && !flash;

  issue_queue_mem #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk      (clk),
    .i_we0    (w_update && (w_accept != 2'd0)),
    .i_waddr0 (r_tail),
    .i_wdata0 (push_data[0]),
    .i_we1    (w_update && (w_accept == 2'd2)),
    .i_waddr1 (r_tail + AW'(1)),
    .i_wdata1 (push_data[1]),
    .i_raddr0 (r_head),
    .o_rdata0 (w_rdata0),
    .i_raddr1 (r_head + AW'(1)),
    .o_rdata1 (w_rdata1)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (flash) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      r_head  <= r_head + AW'(w_eff_pop);
      r_tail  <= r_tail + AW'(w_accept);
      r_count <= r_count - CNT_W'(w_eff_pop) + CNT_W'(w_accept);
    end
  end

  // Slots beyond the occupancy are masked so stale storage never leaks out.
  always_comb begin
    issue_require = '0;
    if (r_count != '0) begin
      issue_require[0] = w_rdata0;
    end
    if (r_count >= CNT_W'(2)) begin
      issue_require[1] = w_rdata1;
    end
  end

  assign push_ready = w_push_ready;
  assign iq_size    = w_iq_size;
  assign iq_count   = r_count;

`ifdef ISSUE_QUEUE_STATS_EN
  logic [31:0] r_stall_cycles;

  // Counts any nonzero request, including the illegal value 3, while full.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cycles <= '0;
    end else if ((push_number != 2'd0) && !w_push_ready &&
                 (r_stall_cycles != '1)) begin
      r_stall_cycles <= r_stall_cycles + 32'd1;
    end
  end

  assign stall_cycles = r_stall_cycles;
`endif

endmodule

// File: tb/tb_issue_queue.sv
module tb_issue_queue;
  import issue_queue_pkg::*;

  localparam int DEPTH = IQ_DEPTH;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic                     clk = 1'b0;
  logic                     rst = 1'b1;
  logic                     flash = 1'b0;
  logic [1:0]               push_number = '0;
  ISSUE_QUEUE_ELEMENT [1:0] push_data = '0;
  logic                     push_ready;
  ISSUE_QUEUE_ELEMENT [1:0] issue_require;
  logic [1:0]               iq_size;
  logic [1:0]               iq_pop_number = '0;
  logic [CNT_W-1:0]         iq_count;
`ifdef ISSUE_QUEUE_STATS_EN
  logic [31:0]              stall_cycles;
`endif

  issue_queue #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .flash         (flash),
    .push_number   (push_number),
    .push_data     (push_data),
    .push_ready    (push_ready),
    .issue_require (issue_require),
    .iq_size       (iq_size),
    .iq_pop_number (iq_pop_number),
    .iq_count      (iq_count)
`ifdef ISSUE_QUEUE_STATS_EN
    ,
    .stall_cycles  (stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  // Reference model: an ordered list of accepted entries plus a stall tally.
  ISSUE_QUEUE_ELEMENT model_q[$];
  logic [31:0]        model_stall = '0;

  int n_vec = 0;
  int n_err = 0;

  function automatic ISSUE_QUEUE_ELEMENT mk(input logic [31:0] pc);
    ISSUE_QUEUE_ELEMENT e;
    e.pc       = pc;
    e.rs1      = 5'($urandom);
    e.rs2      = 5'($urandom);
    e.rd       = 5'($urandom);
    e.rd_valid = 1'($urandom);
    e.imm      = $urandom;
    return e;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs,
                     input logic [127:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    ISSUE_QUEUE_ELEMENT e0;
    ISSUE_QUEUE_ELEMENT e1;
    int sz;
    sz = model_q.size();
    e0 = '0;
    e1 = '0;
    if (sz > 0) e0 = model_q[0];
    if (sz > 1) e1 = model_q[1];
    chk("iq_count", 128'(iq_count), 128'(sz));
    chk("push_ready", 128'(push_ready), 128'((DEPTH - sz) >= 2));
    chk("iq_size", 128'(iq_size), 128'((sz > 2) ? 2 : sz));
    chk("issue_require0", 128'(issue_require[0]), 128'(e0));
    chk("issue_require1", 128'(issue_require[1]), 128'(e1));
`ifdef ISSUE_QUEUE_STATS_EN
    chk("stall_cycles", 128'(stall_cycles), 128'(model_stall));
`endif
  endtask

  // One clock of stimulus: drive, advance the model, clock, then compare.
  task automatic step(input int num, input ISSUE_QUEUE_ELEMENT d0,
                      input ISSUE_QUEUE_ELEMENT d1, input int pop,
                      input bit fl, input bit rs);
    int sz;
    int avail;
    int eff;
    bit ready;
    push_number   = 2'(num);
    push_data[0]  = d0;
    push_data[1]  = d1;
    iq_pop_number = 2'(pop);
    flash         = fl;
    rst           = rs;
    if (!rs && !fl) chk("pop_within_size", 128'(iq_pop_number <= iq_size), 128'(1));

    sz    = model_q.size();
    ready = (DEPTH - sz) >= 2;
    if (rs) model_stall = '0;
    else if (num != 0 && !ready && model_stall != 32'hFFFF_FFFF) model_stall++;

    if (rs || fl) begin
      model_q.delete();
    end else begin
      avail = (sz > 2) ? 2 : sz;
      eff   = (pop > avail) ? avail : pop;
      repeat (eff) void'(model_q.pop_front());
      if (ready && (num == 1 || num == 2)) begin
        model_q.push_back(d0);
        if (num == 2) model_q.push_back(d1);
      end
    end

    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic idle(input int pop);
    step(0, '0, '0, pop, 1'b0, 1'b0);
  endtask

  task automatic push(input int num, input logic [31:0] pc, input int pop);
    step(num, mk(pc), mk(pc + 32'd4), pop, 1'b0, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] stall_snap;
    int rpop;
    int rnum;

    // Reset then idle
    step(0, '0, '0, 0, 1'b0, 1'b1);
    step(0, '0, '0, 0, 1'b0, 1'b1);
    idle(0);
    chk("reset_iq_size", 128'(iq_size), 128'(0));
    chk("reset_push_ready", 128'(push_ready), 128'(1));
    chk("reset_iq_count", 128'(iq_count), 128'(0));
    chk("reset_issue_require", 128'(issue_require), 128'(0));

    // Dual push, dual pop
    push(2, 32'h100, 0);
    chk("dual_iq_size", 128'(iq_size), 128'(2));
    chk("dual_pc0", 128'(issue_require[0].pc), 128'(32'h100));
    chk("dual_pc1", 128'(issue_require[1].pc), 128'(32'h104));
    idle(2);
    chk("dual_after_pop", 128'(iq_count), 128'(0));

    // Fill to full, then one push that must be refused
    for (int i = 0; i < 4; i++) push(2, 32'h1000 + 32'(8 * i), 0);
    chk("full_iq_count", 128'(iq_count), 128'(8));
    chk("full_push_ready", 128'(push_ready), 128'(0));
    push(2, 32'h1100, 0);
    chk("full_ignored", 128'(iq_count), 128'(8));
    for (int i = 0; i < 4; i++) idle(2);

    // Wrap-around across index 7 -> 0
    step(0, '0, '0, 0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) push(2, 32'h200 + 32'(8 * i), 0);
    idle(2);
    idle(2);
    idle(1);
    for (int i = 0; i < 3; i++) push(2, 32'h218 + 32'(8 * i), 0);
    chk("wrap_iq_count", 128'(iq_count), 128'(7));
    for (int i = 0; i < 7; i++) begin
      chk("wrap_order", 128'(issue_require[0].pc), 128'(32'h214 + 32'(4 * i)));
      idle(1);
    end

    // Simultaneous push/pop at count 3
    push(2, 32'h300, 0);
    push(1, 32'h308, 0);
    push(2, 32'h30C, 1);
    chk("simul_iq_count", 128'(iq_count), 128'(4));
    chk("simul_head", 128'(issue_require[0].pc), 128'(32'h304));

    // Flash with a push pending at count 5
    push(1, 32'h314, 0);
    chk("flash_pre_count", 128'(iq_count), 128'(5));
    stall_snap = model_stall;
    step(2, mk(32'h400), mk(32'h404), 0, 1'b1, 1'b0);
    chk("flash_iq_count", 128'(iq_count), 128'(0));
    chk("flash_iq_size", 128'(iq_size), 128'(0));
`ifdef ISSUE_QUEUE_STATS_EN
    chk("flash_stall_kept", 128'(stall_cycles), 128'(stall_snap));
`endif

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      rnum = $urandom_range(0, 3);
      rpop = $urandom_range(0, (model_q.size() > 2) ? 2 : model_q.size());
      step(rnum, mk($urandom), mk($urandom), rpop,
           ($urandom_range(0, 19) == 0), ($urandom_range(0, 99) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
